i2c_master_byte: RTL and testbench

- Synchronous I2C controller (initiator) for single-byte transactions: one write or one read per request, 7-bit addressing.
- Counterpart to the team's I2C responder: generates SCL, START/STOP, address and data framing, and checks ACK.
- Sits between a simple request/response user interface and the open-drain bus lines.
- Single controller only; no arbitration, no clock stretching.

---
 rtl/i2c_master_byte.sv | 222 ++++++++++++++++++++++
 tb/tb_i2c_master_byte.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_byte.sv
// rtl/i2c_master_byte.sv - single-byte I2C controller (initiator) with 7-bit addressing
module i2c_master_byte #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] dev_addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       m_SCL,
   inout  wire        m_SDA
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_START,
      S_ADDR,
      S_ADDR_ACK,
      S_WDATA,
      S_WACK,
      S_RDATA,
      S_RNACK,
      S_STOP
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      qtr_q, qtr_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      wdata_q, wdata_d;
   logic            rw_q, rw_d;
   logic            nack_q, nack_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ack_err_q, ack_err_d;

   logic            tick;
   logic            sample_pt;
   logic            slot_end;
   logic            scl_c;
   logic            sda_low_c;

   // A quarter ends on the divider terminal count; the bus is sampled at the end of q2.
   assign tick      = (cnt_q == CW'(CLK_DIV - 1));
   assign sample_pt = tick && (qtr_q == 2'd2);
   assign slot_end  = tick && (qtr_q == 2'd3);

   // State, divider, quarter and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         qtr_q     <= 2'd0;
         bit_q     <= 3'd7;
         shift_q   <= 8'h00;
         wdata_q   <= 8'h00;
         rw_q      <= 1'b0;
         nack_q    <= 1'b0;
         rdata_q   <= 8'h00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         qtr_q     <= qtr_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         wdata_q   <= wdata_d;
         rw_q      <= rw_d;
         nack_q    <= nack_d;
         rdata_q   <= rdata_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
      end
   end

   // Next-state logic: one FSM phase per quarter, transitions only at slot ends
   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      wdata_d   = wdata_q;
      rw_d      = rw_q;
      nack_d    = nack_q;
      rdata_d   = rdata_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ack_err_d = ack_err_q;

      // Divider and quarter counter are parked at zero while idle
      if (state_q == S_IDLE) begin
         cnt_d = '0;
         qtr_d = 2'd0;
      end else begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
         qtr_d = tick ? qtr_q + 2'd1 : qtr_q;
      end

      case (state_q)
         S_IDLE: begin
            // A request landing on the done cycle is dropped on purpose
            if (start && !done_q) begin
               state_d   = S_START;
               rw_d      = rw;
               shift_d   = {dev_addr, rw};
               wdata_d   = wdata;
               ack_err_d = 1'b0;
               busy_d    = 1'b1;
            end
         end
         S_START: begin
            if (slot_end) begin
               state_d = S_ADDR;
               bit_d   = 3'd7;
            end
         end
         S_ADDR, S_WDATA: begin
            if (slot_end) begin
               shift_d = {shift_q[6:0], 1'b0};
               bit_d   = bit_q - 3'd1;
               if (bit_q == 3'd0) begin
                  state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_WACK;
               end
            end
         end
         S_ADDR_ACK, S_WACK: begin
            if (sample_pt) begin
               nack_d = m_SDA;
            end
            if (slot_end) begin
               bit_d = 3'd7;
               if (nack_q) begin
                  ack_err_d = 1'b1;
                  state_d   = S_STOP;
               end else if (state_q == S_WACK) begin
                  state_d = S_STOP;
               end else if (rw_q) begin
                  state_d = S_RDATA;
               end else begin
                  state_d = S_WDATA;
                  shift_d = wdata_q;
               end
            end
         end
         S_RDATA: begin
            if (sample_pt) begin
               shift_d = {shift_q[6:0], m_SDA};
            end
            if (slot_end) begin
               bit_d = bit_q - 3'd1;
               if (bit_q == 3'd0) begin
                  state_d = S_RNACK;
               end
            end
         end
         S_RNACK: begin
            if (slot_end) begin
               rdata_d = shift_q;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (slot_end) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Bus drive: SCL high in q1/q2 of data slots, SDA moves only while SCL is low
   always_comb begin
      scl_c     = 1'b1;
      sda_low_c = 1'b0;
      case (state_q)
         S_START: begin
            scl_c     = (qtr_q != 2'd3);
            sda_low_c = qtr_q[1];
         end
         S_ADDR, S_WDATA: begin
            scl_c     = (qtr_q == 2'd1) || (qtr_q == 2'd2);
            sda_low_c = ~shift_q[7];
         end
         S_ADDR_ACK, S_WACK, S_RDATA, S_RNACK: begin
            scl_c     = (qtr_q == 2'd1) || (qtr_q == 2'd2);
            sda_low_c = 1'b0;
         end
         S_STOP: begin
            scl_c     = (qtr_q != 2'd0);
            sda_low_c = ~qtr_q[1];
         end
         default: begin
            scl_c     = 1'b1;
            sda_low_c = 1'b0;
         end
      endcase
   end

   assign m_SCL   = scl_c;
   assign m_SDA   = sda_low_c ? 1'b0 : 1'bz;
   assign rdata   = rdata_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// tb/tb_i2c_master_byte.sv - scoreboard bench with I2C responder model and bus checker
module tb_i2c_master_byte;

   localparam int         C         = 4;
   localparam logic [6:0] RESP_ADDR = 7'h0B;

   typedef struct {
      string      tag;
      logic [7:0] addr_byte;
      logic [7:0] wd;
      bit         chk_wd;
      bit         chk_mack;
      logic [7:0] rdata;
      logic       err;
      int         lat;
      int         rises;
      int         t_acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       rw;
   logic [6:0] dev_addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       busy;
   logic       done;
   logic       ack_err;
   logic       m_scl;
   logic       drv_low = 1'b0;
   wire        sda;

   pullup (sda);
   assign sda = drv_low ? 1'b0 : 1'bz;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         n_done  = 0;
   logic [7:0] model_rdata = 8'h00;
   logic [7:0] resp_rd     = 8'h00;
   exp_t       sb[$];

   i2c_master_byte #(.CLK_DIV(C)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .rw       (rw),
      .dev_addr (dev_addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .busy     (busy),
      .done     (done),
      .ack_err  (ack_err),
      .m_SCL    (m_scl),
      .m_SDA    (sda)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bus checker, responder model and done-side scoreboard, all sampled on the falling clock edge
   initial begin : mon
      logic       scl_p, sda_p, obs_mack;
      bit         high_ok, low_ok;
      int         t_rise, t_fall, n_rise, n_start, n_stop, r_phase, r_cnt, lat;
      logic [7:0] r_sh, obs_addr, obs_wd;
      exp_t       e;
      scl_p = 1'b1; sda_p = 1'b1; obs_mack = 1'b0;
      high_ok = 0; low_ok = 0; t_rise = 0; t_fall = 0;
      n_rise = 0; n_start = 0; n_stop = 0; r_phase = 0; r_cnt = 0;
      r_sh = 8'h00; obs_addr = 8'h00; obs_wd = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            high_ok = 0; low_ok = 0; n_rise = 0; n_start = 0; n_stop = 0;
            r_phase = 0; r_cnt = 0; drv_low = 1'b0;
            obs_addr = 8'h00; obs_wd = 8'h00; obs_mack = 1'b0;
         end else begin
            // SDA may only move under a high SCL for START (fall) and STOP (rise)
            if (scl_p && m_scl && (sda !== sda_p)) begin
               if (sda === 1'b0) n_start++;
               else n_stop++;
            end
            if (!scl_p && m_scl) begin
               n_rise++;
               if (low_ok) check("scl_low_time", 32'(cyc - t_fall), 32'(2 * C));
               t_rise  = cyc;
               high_ok = 1;
            end
            if (scl_p && !m_scl) begin
               if (high_ok) check("scl_high_time", 32'(cyc - t_rise), 32'(2 * C));
               t_fall  = cyc;
               low_ok  = 1;
               high_ok = 0;
            end

            // Responder: address RESP_ADDR, ACKs address and write data, returns resp_rd on reads
            if (scl_p && m_scl && sda_p && !sda) begin
               r_phase = 1; r_cnt = 0; drv_low = 1'b0;
            end else if (scl_p && m_scl && !sda_p && sda) begin
               r_phase = 0; drv_low = 1'b0;
            end else if (r_phase != 0 && !scl_p && m_scl) begin
               r_cnt++;
               if (r_cnt <= 8) r_sh = {r_sh[6:0], sda};
               else if (r_phase == 3) obs_mack = sda;
            end else if (r_phase != 0 && scl_p && !m_scl) begin
               if (r_cnt == 8) begin
                  if (r_phase == 1) begin
                     obs_addr = r_sh;
                     drv_low  = (r_sh[7:1] == RESP_ADDR);
                  end else if (r_phase == 2) begin
                     obs_wd  = r_sh;
                     drv_low = 1'b1;
                  end else begin
                     drv_low = 1'b0;
                  end
               end else if (r_cnt == 9) begin
                  drv_low = 1'b0;
                  r_cnt   = 0;
                  if (r_phase == 1 && obs_addr[7:1] == RESP_ADDR) begin
                     if (obs_addr[0]) begin
                        r_phase = 3;
                        drv_low = !resp_rd[7];
                     end else begin
                        r_phase = 2;
                     end
                  end else begin
                     r_phase = 0;
                  end
               end else if (r_phase == 3 && r_cnt >= 1) begin
                  drv_low = !resp_rd[7 - r_cnt];
               end
            end

            // Scoreboard: every done must match the oldest outstanding request
            if (done) begin
               n_done++;
               check("done_expected", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) begin
                  e   = sb.pop_front();
                  lat = cyc - e.t_acc;
                  n_tests++;
                  assert (lat >= e.lat - 1 && lat <= e.lat + 1) else begin
                     n_fail++;
                     $error("FAIL %s_latency: observed %0d expected %0d", e.tag, lat, e.lat);
                  end
                  check({e.tag, "_ack_err"},   32'(ack_err),  32'(e.err));
                  check({e.tag, "_rdata"},     32'(rdata),    32'(e.rdata));
                  check({e.tag, "_busy_low"},  32'(busy),     32'd0);
                  check({e.tag, "_addr_byte"}, 32'(obs_addr), 32'(e.addr_byte));
                  check({e.tag, "_scl_rises"}, 32'(n_rise),   32'(e.rises));
                  check({e.tag, "_starts"},    32'(n_start),  32'd1);
                  check({e.tag, "_stops"},     32'(n_stop),   32'd1);
                  if (e.chk_wd)   check({e.tag, "_wdata_bits"}, 32'(obs_wd),   32'(e.wd));
                  if (e.chk_mack) check({e.tag, "_master_nack"}, 32'(obs_mack), 32'd1);
               end
               n_rise = 0; n_start = 0; n_stop = 0; high_ok = 0;
               obs_addr = 8'h00; obs_wd = 8'h00; obs_mack = 1'b0;
            end
         end
         scl_p = m_scl;
         sda_p = sda;
      end
   end

   // Drive a one-cycle request from a falling edge, then scramble the fields
   task automatic issue(input bit r, input logic [6:0] a, input logic [7:0] wd);
      start = 1'b1; rw = r; dev_addr = a; wdata = wd;
      @(negedge clk);
      start = 1'b0; rw = 1'($urandom); dev_addr = 7'($urandom); wdata = 8'($urandom);
   endtask

   task automatic expect_txn(input string tag, input bit r, input logic [6:0] a,
                             input logic [7:0] wd, input logic [7:0] rd_model);
      exp_t e;
      bit   err;
      err         = (a != RESP_ADDR);
      e.tag       = tag;
      e.addr_byte = {a, r};
      e.wd        = wd;
      e.chk_wd    = !r && !err;
      e.chk_mack  = r && !err;
      if (r && !err) model_rdata = rd_model;
      e.rdata     = model_rdata;
      e.err       = err;
      e.lat       = err ? 44 * C : 80 * C;
      e.rises     = err ? 10 : 19;
      e.t_acc     = cyc;
      sb.push_back(e);
      check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!done && n < 120 * C) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, 32'(done), 32'd1);
   endtask

   task automatic run_txn(input string tag, input bit r, input logic [6:0] a,
                          input logic [7:0] wd, input logic [7:0] rd_model);
      resp_rd = rd_model;
      issue(r, a, wd);
      expect_txn(tag, r, a, wd, rd_model);
      wait_done(tag);
      @(negedge clk);
   endtask

   initial begin : main
      int done_before;
      rst = 1'b1; start = 1'b0; rw = 1'b0; dev_addr = 7'h00; wdata = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_done",    32'(done),    32'd0);
      check("rst_ack_err", 32'(ack_err), 32'd0);
      check("rst_rdata",   32'(rdata),   32'h00);
      check("rst_scl",     32'(m_scl),   32'd1);
      check("rst_sda",     32'(sda),     32'd1);
      rst = 1'b0;
      @(negedge clk);

      run_txn("wr",      1'b0, 7'h0B, 8'hA5, 8'h00);
      run_txn("rd",      1'b1, 7'h0B, 8'h00, 8'h96);
      run_txn("nack_rd", 1'b1, 7'h22, 8'h00, 8'h33);

      // Requests while busy and on the done cycle are dropped
      resp_rd = 8'h00;
      issue(1'b0, 7'h0B, 8'h3C);
      expect_txn("guard_wr", 1'b0, 7'h0B, 8'h3C, 8'h00);
      repeat (10 * C) @(negedge clk);
      start = 1'b1; rw = 1'b1; dev_addr = 7'h22; wdata = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      check("guard_busy_kept", 32'(busy), 32'd1);
      wait_done("guard_wr");
      start = 1'b1; rw = 1'b1; dev_addr = 7'h22; wdata = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      check("done_cycle_start_ignored", 32'(busy), 32'd0);
      resp_rd = 8'h5A;
      issue(1'b1, 7'h0B, 8'h00);
      expect_txn("guard_rd", 1'b1, 7'h0B, 8'h00, 8'h5A);
      wait_done("guard_rd");
      @(negedge clk);

      // Reset during data bit 3 (a 0 bit) of a write
      issue(1'b0, 7'h0B, 8'hC3);
      repeat (56 * C) @(negedge clk);
      check("pre_rst_scl_low", 32'(m_scl), 32'd0);
      check("pre_rst_sda_low", 32'(sda),   32'd0);
      done_before = n_done;
      rst = 1'b1;
      model_rdata = 8'h00;
      @(negedge clk);
      check("midrst_scl",  32'(m_scl), 32'd1);
      check("midrst_sda",  32'(sda),   32'd1);
      check("midrst_busy", 32'(busy),  32'd0);
      check("midrst_done", 32'(done),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (100 * C) @(negedge clk);
      check("midrst_no_done", 32'(n_done), 32'(done_before));

      run_txn("post_rst_wr", 1'b0, 7'h0B, 8'h81, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
